// File: rtl/apb_slice_pkg.sv
// Shared types and constants for the APB timeout slice.
package apb_slice_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;
  localparam int          TO_CNT_W          = 8;
  localparam int          WAIT_CNT_W        = 16;

endpackage

// File: rtl/apb_wait_counter.sv
// Downstream wait-state counter: clears at transfer start, counts stalled
// access cycles, flags when the abort limit is reached. Saturates so it can
// never wrap inside one transfer.
module apb_wait_counter
  import apb_slice_pkg::*;
(
  input  logic                  clk_sys_i,
  input  logic                  rst_b_i,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [WAIT_CNT_W-1:0] limit_i,
  output logic                  hit_o
);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  // next count: clear wins, otherwise saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WAIT_CNT_W'(1);
    end
  end

  // count register
  always_ff @(posedge clk_sys_i or negedge rst_b_i) begin
    if (!rst_b_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign hit_o = (cnt_q == (limit_i - WAIT_CNT_W'(1)));

endmodule

// File: rtl/apb_timeout_slice.sv
// APB slice that forwards one upstream transfer to a downstream slave and
// aborts it with an error response if the slave stalls too long.
//
// state  | meaning
// IDLE   | waiting for an upstream setup phase
// SETUP  | downstream setup phase (M_PSEL=1, M_PENABLE=0)
// ACCESS | downstream access phase, waiting on M_PREADY or timeout
// RESP   | one-cycle upstream completion (PREADY=1)
module apb_timeout_slice
  import apb_slice_pkg::*;
#(
  parameter int          APB_ADDR_WIDTH = 32,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [APB_ADDR_WIDTH-1:0] M_PADDR,
  output logic [31:0]               M_PWDATA,
  output logic                      M_PWRITE,
  output logic                      M_PSEL,
  output logic                      M_PENABLE,
  input  logic [31:0]               M_PRDATA,
  input  logic                      M_PREADY,
  input  logic                      M_PSLVERR,
  output logic                      timeout_o,
  output logic [TO_CNT_W-1:0]       timeout_cnt_o
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(TIMEOUT_CYCLES);

  apb_state_t                state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      m_psel_q, m_psel_d;
  logic                      m_penable_q, m_penable_d;
  logic [31:0]               prdata_q, prdata_d;
  logic                      pslverr_q, pslverr_d;
  logic                      pready_q, pready_d;
  logic                      timeout_q, timeout_d;
  logic [TO_CNT_W-1:0]       to_cnt_q, to_cnt_d;
  logic                      drop_q, drop_d;
  logic                      done, abandon;
  logic                      wc_clr, wc_en, wc_hit;

  apb_wait_counter u_wait_counter (
    .clk_sys_i (HCLK),
    .rst_b_i   (HRESETn),
    .clr_i     (wc_clr),
    .en_i      (wc_en),
    .limit_i   (LIMIT),
    .hit_o     (wc_hit)
  );

  // transfer sequencing; upstream response regs are only non-zero in RESP
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    m_psel_d    = m_psel_q;
    m_penable_d = m_penable_q;
    prdata_d    = '0;
    pslverr_d   = 1'b0;
    pready_d    = 1'b0;
    timeout_d   = 1'b0;
    to_cnt_d    = to_cnt_q;
    drop_d      = drop_q;
    done        = 1'b0;
    abandon     = 1'b0;
    wc_clr      = 1'b0;
    wc_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d     = ST_SETUP;
          paddr_d     = PADDR;
          pwdata_d    = PWDATA;
          pwrite_d    = PWRITE;
          m_psel_d    = 1'b1;
          m_penable_d = 1'b0;
          drop_d      = 1'b0;
          wc_clr      = 1'b1;
        end
      end
      ST_SETUP: begin
        state_d     = ST_ACCESS;
        m_penable_d = 1'b1;
        if (!PSEL) drop_d = 1'b1;
      end
      ST_ACCESS: begin
        // a master that let go of PSEL no longer wants the answer
        abandon = drop_q || !PSEL;
        wc_en   = !M_PREADY;
        if (M_PREADY) begin
          done      = 1'b1;
          prdata_d  = pwrite_q ? 32'h0 : M_PRDATA;
          pslverr_d = M_PSLVERR;
        end else if (wc_hit) begin
          done      = 1'b1;
          prdata_d  = ERR_RDATA;
          pslverr_d = 1'b1;
          timeout_d = 1'b1;
          if (to_cnt_q != '1) to_cnt_d = to_cnt_q + TO_CNT_W'(1);
        end
        if (done) begin
          m_psel_d    = 1'b0;
          m_penable_d = 1'b0;
          if (abandon) begin
            state_d   = ST_IDLE;
            prdata_d  = '0;
            pslverr_d = 1'b0;
          end else begin
            state_d  = ST_RESP;
            pready_d = 1'b1;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        m_psel_d    = 1'b0;
        m_penable_d = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      m_psel_q    <= 1'b0;
      m_penable_q <= 1'b0;
      prdata_q    <= '0;
      pslverr_q   <= 1'b0;
      pready_q    <= 1'b0;
      timeout_q   <= 1'b0;
      to_cnt_q    <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      m_psel_q    <= m_psel_d;
      m_penable_q <= m_penable_d;
      prdata_q    <= prdata_d;
      pslverr_q   <= pslverr_d;
      pready_q    <= pready_d;
      timeout_q   <= timeout_d;
      to_cnt_q    <= to_cnt_d;
      drop_q      <= drop_d;
    end
  end

  assign PRDATA        = prdata_q;
  assign PREADY        = pready_q;
  assign PSLVERR       = pslverr_q;
  assign M_PADDR       = paddr_q;
  assign M_PWDATA      = pwdata_q;
  assign M_PWRITE      = pwrite_q;
  assign M_PSEL        = m_psel_q;
  assign M_PENABLE     = m_penable_q;
  assign timeout_o     = timeout_q;
  assign timeout_cnt_o = to_cnt_q;

endmodule

// File: tb/tb_apb_timeout_slice.sv
// Directed bench for apb_timeout_slice with a transfer-level reference model.
module tb_apb_timeout_slice;

  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        HCLK, HRESETn;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
  logic [31:0] M_PADDR, M_PWDATA, M_PRDATA;
  logic        M_PWRITE, M_PSEL, M_PENABLE, M_PREADY, M_PSLVERR;
  logic        timeout_o;
  logic [7:0]  timeout_cnt_o;

  apb_timeout_slice #(.APB_ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .M_PADDR(M_PADDR), .M_PWDATA(M_PWDATA), .M_PWRITE(M_PWRITE), .M_PSEL(M_PSEL),
    .M_PENABLE(M_PENABLE), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY), .M_PSLVERR(M_PSLVERR),
    .timeout_o(timeout_o), .timeout_cnt_o(timeout_cnt_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 0;
  int pulses = 0;

  // transfer-level model
  bit          mdl_valid = 0;
  int          mdl_t0 = -100, mdl_resp = -100, mdl_cnt = 0;
  bit          mdl_to, mdl_discard;
  logic [31:0] mdl_rdata, mdl_addr, mdl_wdata;
  logic        mdl_err, mdl_write;

  // behavioural downstream slave
  int          sl_waits = 0, acc = 0;
  logic [31:0] sl_rdata = 0;
  logic        sl_err = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_write;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  initial begin
    HCLK = 0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  // slave: ready after sl_waits stalled access cycles (-1 = never)
  initial forever begin
    @(negedge HCLK);
    if (M_PSEL && M_PENABLE) begin
      cap_addr  = M_PADDR;
      cap_wdata = M_PWDATA;
      cap_write = M_PWRITE;
      M_PREADY  = (sl_waits >= 0) && (acc == sl_waits);
      M_PRDATA  = M_PREADY ? sl_rdata : 32'h0BAD_0000;
      M_PSLVERR = M_PREADY ? sl_err : 1'b0;
      acc++;
    end else begin
      acc = 0;
      M_PREADY = 0; M_PRDATA = 0; M_PSLVERR = 0;
    end
  end

  // per-cycle comparison against the model
  initial forever begin
    bit in_resp, exp_rdy, exp_sel, exp_en;
    @(posedge HCLK);
    cyc++;
    #1;
    if (cmp_en) begin
      in_resp = mdl_valid && (cyc == mdl_resp);
      if (in_resp && mdl_to) mdl_cnt = (mdl_cnt < 255) ? mdl_cnt + 1 : 255;
      exp_rdy = in_resp && !mdl_discard;
      exp_sel = mdl_valid && (cyc > mdl_t0) && (cyc < mdl_resp);
      exp_en  = mdl_valid && (cyc > mdl_t0 + 1) && (cyc < mdl_resp);
      chk("pready", PREADY, exp_rdy);
      chk("prdata", PRDATA, exp_rdy ? mdl_rdata : 32'h0);
      chk("pslverr", PSLVERR, exp_rdy ? mdl_err : 1'b0);
      chk("timeout_o", timeout_o, in_resp && mdl_to);
      chk("timeout_cnt", 32'(timeout_cnt_o), mdl_cnt);
      chk("m_psel", M_PSEL, exp_sel);
      chk("m_penable", M_PENABLE, exp_en);
      if (exp_sel) begin
        chk("m_paddr", M_PADDR, mdl_addr);
        chk("m_pwdata", M_PWDATA, mdl_wdata);
        chk("m_pwrite", M_PWRITE, mdl_write);
      end
      if (timeout_o) pulses++;
    end
  end

  task automatic model_start(input logic [31:0] a, input logic [31:0] wd, input logic w,
                             input int waits, input logic [31:0] rd, input logic e, input bit disc);
    mdl_t0      = cyc;
    mdl_to      = (waits < 0) || (waits >= TO);
    mdl_resp    = cyc + 3 + (mdl_to ? TO - 1 : waits);
    mdl_rdata   = mdl_to ? ERR : (w ? 32'h0 : rd);
    mdl_err     = mdl_to ? 1'b1 : e;
    mdl_addr    = a;
    mdl_wdata   = wd;
    mdl_write   = w;
    mdl_discard = disc;
    mdl_valid   = 1;
  endtask

  task automatic do_xfer(input logic [31:0] a, input logic [31:0] wd, input logic w,
                         input int waits, input logic [31:0] rd, input logic e, input int drop_at,
                         output int lat, output logic [31:0] got_rd, output logic got_err);
    int t0;
    @(negedge HCLK);
    sl_waits = waits; sl_rdata = rd; sl_err = e;
    model_start(a, wd, w, waits, rd, e, drop_at >= 0);
    t0 = cyc;
    PADDR = a; PWDATA = wd; PWRITE = w; PSEL = 1; PENABLE = 0;
    @(negedge HCLK);
    PENABLE = 1;
    lat = -1; got_rd = 'x; got_err = 'x;
    for (int i = 0; i < 40; i++) begin
      if (drop_at >= 0 && (cyc - t0) == drop_at) begin PSEL = 0; PENABLE = 0; end
      if (PREADY) begin
        lat = cyc - t0; got_rd = PRDATA; got_err = PSLVERR;
        break;
      end
      if (drop_at >= 0 && (cyc - t0) >= 10) break;
      @(negedge HCLK);
    end
    @(negedge HCLK);
    PSEL = 0; PENABLE = 0;
  endtask

  initial begin
    int lat;
    logic [31:0] rd;
    logic se;
    HRESETn = 0;
    PADDR = 0; PWDATA = 0; PWRITE = 0; PSEL = 0; PENABLE = 0;
    M_PREADY = 0; M_PRDATA = 0; M_PSLVERR = 0;
    #3;
    chk("rst_pready", PREADY, 0);
    chk("rst_prdata", PRDATA, 0);
    chk("rst_m_psel", M_PSEL, 0);
    chk("rst_m_paddr", M_PADDR, 0);
    chk("rst_timeout_cnt", 32'(timeout_cnt_o), 0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1;
    cmp_en = 1;

    // zero-wait read
    do_xfer(32'h1A10_3004, 32'h0, 0, 0, 32'h0000_00AA, 0, -1, lat, rd, se);
    chk("rd0_latency", lat, 3);
    chk("rd0_prdata", rd, 32'h0000_00AA);
    chk("rd0_pslverr", se, 0);
    chk("rd0_m_paddr", cap_addr, 32'h1A10_3004);

    // write, three wait states
    do_xfer(32'h2000_0010, 32'h1234_5678, 1, 3, 32'h5555_5555, 0, -1, lat, rd, se);
    chk("wr3_latency", lat, 6);
    chk("wr3_prdata", rd, 32'h0);
    chk("wr3_m_pwdata", cap_wdata, 32'h1234_5678);
    chk("wr3_m_pwrite", cap_write, 1);

    // slave never ready
    do_xfer(32'h3000_0000, 32'h0, 0, -1, 32'h0, 0, -1, lat, rd, se);
    chk("to_latency", lat, 6);
    chk("to_prdata", rd, 32'hDEAD_BEEF);
    chk("to_pslverr", se, 1);
    chk("to_cnt", 32'(timeout_cnt_o), 1);
    chk("to_pulses", pulses, 1);

    // ready with error exactly on the limit cycle
    do_xfer(32'h3000_0004, 32'h0, 0, TO - 1, 32'hC0DE_0029, 1, -1, lat, rd, se);
    chk("lim_latency", lat, 6);
    chk("lim_prdata", rd, 32'hC0DE_0029);
    chk("lim_pslverr", se, 1);
    chk("lim_cnt", 32'(timeout_cnt_o), 1);
    chk("lim_pulses", pulses, 1);

    // PSEL dropped mid-transfer: completes downstream, no upstream response
    do_xfer(32'h4000_0000, 32'h0, 0, 1, 32'h7777_0001, 0, 2, lat, rd, se);
    chk("drop_no_pready", lat, -1);
    do_xfer(32'h4000_0008, 32'h0, 0, -1, 32'h0, 0, 2, lat, rd, se);
    chk("drop_to_no_pready", lat, -1);
    chk("drop_to_cnt", 32'(timeout_cnt_o), 2);

    // zero-wait write with slave error, then a two-wait read
    do_xfer(32'h5000_0020, 32'hA5A5_5A5A, 1, 0, 32'h1111_1111, 1, -1, lat, rd, se);
    chk("wrerr_latency", lat, 3);
    chk("wrerr_prdata", rd, 32'h0);
    chk("wrerr_pslverr", se, 1);
    do_xfer(32'h5000_0024, 32'h0, 0, 2, 32'h0F0F_F0F0, 0, -1, lat, rd, se);
    chk("rd2_latency", lat, 5);
    chk("rd2_prdata", rd, 32'h0F0F_F0F0);

    // reset during ACCESS
    @(negedge HCLK);
    sl_waits = -1;
    model_start(32'h6000_0000, 32'h0, 0, -1, 32'h0, 0, 0);
    PADDR = 32'h6000_0000; PWRITE = 0; PSEL = 1; PENABLE = 0;
    @(negedge HCLK);
    PENABLE = 1;
    @(negedge HCLK);
    chk("pre_rst_m_penable", M_PENABLE, 1);
    mdl_valid = 0; mdl_cnt = 0;
    HRESETn = 0;
    #1;
    chk("rst_mid_m_psel", M_PSEL, 0);
    chk("rst_mid_m_penable", M_PENABLE, 0);
    chk("rst_mid_cnt", 32'(timeout_cnt_o), 0);
    @(negedge HCLK);
    PSEL = 0; PENABLE = 0;
    @(negedge HCLK);
    HRESETn = 1;
    do_xfer(32'h6000_0004, 32'h0, 0, 1, 32'h0000_BEEF, 0, -1, lat, rd, se);
    chk("post_rst_latency", lat, 4);
    chk("post_rst_prdata", rd, 32'h0000_BEEF);

    // saturation of the timeout count
    for (int n = 0; n < 300; n++)
      do_xfer(32'h7000_0000 + 32'(n), 32'h0, 0, -1, 32'h0, 0, -1, lat, rd, se);
    chk("sat_cnt", 32'(timeout_cnt_o), 255);

    repeat (2) @(negedge HCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_timeout_slice.md
APB_TIMEOUT_SLICE -- requirements
Module: apb_timeout_slice

Interface
REQ-001 The block SHALL have parameter APB_ADDR_WIDTH, default 32, which sets the address width on both ports.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, range 2..65535, which sets the maximum downstream access-phase cycles before abort.
REQ-003 The block SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF, which is the PRDATA value returned on a timeout.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: HCLK  in  1  clock; HRESETn  in  1  async active-low reset.
REQ-005 Upstream slave port SHALL be: PADDR in APB_ADDR_WIDTH; PWDATA in 32; PWRITE in 1; PSEL in 1; PENABLE in 1; PRDATA out 32; PREADY out 1; PSLVERR out 1.
REQ-006 Downstream master port, feeding the timer/MMU mux, SHALL be: M_PADDR out APB_ADDR_WIDTH; M_PWDATA out 32; M_PWRITE out 1; M_PSEL out 1; M_PENABLE out 1; M_PRDATA in 32; M_PREADY in 1; M_PSLVERR in 1.
REQ-007 Status outputs SHALL be: timeout_o out 1 (one-cycle pulse per aborted transfer); timeout_cnt_o out 8 (saturating count of timeouts).

Function
REQ-008 The FSM SHALL have states IDLE, SETUP, ACCESS and RESP.
REQ-009 In IDLE, when PSEL=1 and PENABLE=0, the block SHALL register PADDR, PWDATA and PWRITE and go to SETUP; in all other IDLE cases it SHALL stay in IDLE.
REQ-010 In SETUP, the block SHALL drive M_PSEL=1 and M_PENABLE=0 with the registered address, data and write, then go to ACCESS.
REQ-011 In ACCESS, the block SHALL drive M_PSEL=1 and M_PENABLE=1, and the wait counter SHALL increment every cycle in which M_PREADY=0.
REQ-012 In ACCESS with M_PREADY=1, the block SHALL register M_PRDATA (reads only; writes register 0) and M_PSLVERR, then go to RESP.
REQ-013 In ACCESS with M_PREADY=0 and wait counter = TIMEOUT_CYCLES-1, the block SHALL register PRDATA=ERR_RDATA and PSLVERR=1, pulse timeout_o in the following cycle, and go to RESP.
REQ-014 If M_PREADY=1 in the same cycle the timeout limit is reached, the block SHALL treat it as a normal completion with no timeout.
REQ-015 In RESP, the block SHALL drive PREADY=1 for exactly one cycle with the registered PRDATA and PSLVERR, then go to IDLE.
REQ-016 Outside RESP, PREADY SHALL be 0, PSLVERR 0 and PRDATA 0.
REQ-017 M_PSEL and M_PENABLE SHALL be 0 in IDLE and RESP, and all M_* outputs SHALL come directly from flops with no combinational path from upstream inputs.
REQ-018 Latency SHALL be: upstream setup at T0, downstream setup at T1, downstream access at T2, PREADY=1 at T3 for a zero-wait slave; each downstream wait state adds one cycle.
REQ-019 If PSEL drops before RESP (protocol violation), the downstream transfer SHALL still complete or time out, the response SHALL be discarded, and the FSM SHALL return to IDLE.
REQ-020 The wait counter SHALL clear on entry to SETUP, be 16 bits wide, and never wrap within one transfer.
REQ-021 timeout_cnt_o SHALL increment on each timeout and saturate at 255.

Reset
REQ-022 On HRESETn=0, asynchronously: state=IDLE; PREADY, PSLVERR, M_PSEL, M_PENABLE, M_PWRITE, timeout_o = 0; PRDATA, M_PADDR, M_PWDATA, wait counter, timeout_cnt_o = 0.
REQ-023 Reset asserted mid-transfer SHALL abort the transfer with no PREADY pulse, and the first transfer after release SHALL start in IDLE.

Structure
REQ-024 Package apb_slice_pkg SHALL hold the FSM state enum, the default ERR_RDATA constant and the timeout-counter width constant.
REQ-025 The block SHALL have one sub-module, apb_wait_counter (clear, enable, limit compare, hit flag); everything else stays flat.

Verification
REQ-026 Zero-wait read: upstream read PADDR=32'h1A10_3004, slave returns 32'h0000_00AA with PREADY at T2 -> PREADY=1 at T3, PRDATA=32'h0000_00AA, PSLVERR=0.
REQ-027 Write with 3 wait states to 32'h2000_0010, PWDATA=32'h1234_5678 -> M_PWDATA matches, PREADY=1 at T6, PRDATA=0.
REQ-028 Slave never ready, TIMEOUT_CYCLES=4 -> PREADY=1 at T6, PSLVERR=1, PRDATA=32'hDEAD_BEEF, timeout_o pulses once, timeout_cnt_o=1.
REQ-029 Slave returns M_PSLVERR=1 on the exact limit cycle -> PSLVERR=1 forwarded, PRDATA=M_PRDATA, no timeout_o, timeout_cnt_o unchanged.
REQ-030 HRESETn low during ACCESS -> M_PSEL=0 immediately; next transfer completes normally; 300 forced timeouts -> timeout_cnt_o=255.
